// File: rtl/bola.sv
// Ball engine for the paddle game: rides the paddle until launched, then moves on a
// fixed tick, reflecting off walls, ceiling and paddle, and counts lives on misses.
module bola #(
    parameter int TICK_DIV       = 250000,
    parameter int PASSO          = 2,
    parameter int LARG_NAVE      = 45,
    parameter int TAM_BOLA       = 8,
    parameter int VIDAS_INICIAIS = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       reiniciarJogo,
    input  logic       pausa,
    input  logic       lancar,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    output logic [9:0] x_bola,
    output logic [9:0] y_bola,
    output logic       bateu,
    output logic       perdeuVida,
    output logic [2:0] vidas,
    output logic       fimDeJogo
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [9:0]  X_OFS = 10'(LARG_NAVE / 2 - TAM_BOLA / 2);
    // Reset position is the ball resting on the paddle at its default 320/410 spot.
    localparam logic [9:0]  X_RST = 10'(320 + LARG_NAVE / 2 - TAM_BOLA / 2);
    localparam logic [9:0]  Y_RST = 10'(410 - TAM_BOLA);
    localparam logic [10:0] T11   = 11'(TAM_BOLA);
    localparam logic [10:0] P11   = 11'(PASSO);
    localparam logic [10:0] L11   = 11'(LARG_NAVE);

    typedef enum logic [1:0] {ESPERA, MOVENDO, PERDEU, FIM} estado_t;

    estado_t       estado, estado_n;
    logic [9:0]    x_n, y_n;
    logic          dir_x, dir_x_n, dir_y, dir_y_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    vidas_n;
    logic          bateu_n, perdeu_n;
    logic          rst, tick, hit;
    logic [10:0]   xb, yb, xn, yn;

    assign rst       = reset | reiniciarJogo;
    assign fimDeJogo = (estado == FIM);
    assign tick      = (cnt == CW'(TICK_DIV - 1)) && !pausa;

    // Widen to 11 bits so edge sums never wrap.
    assign xb = {1'b0, x_bola};
    assign yb = {1'b0, y_bola};
    assign xn = {1'b0, x_nave};
    assign yn = {1'b0, y_nave};

    assign hit = (yb + T11 <= yn) && (yb + T11 + P11 >= yn) &&
                 (xb + T11 > xn) && (xb < xn + L11);

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            estado     <= ESPERA;
            x_bola     <= X_RST;
            y_bola     <= Y_RST;
            dir_x      <= 1'b0;
            dir_y      <= 1'b1;
            cnt        <= '0;
            vidas      <= 3'(VIDAS_INICIAIS);
            bateu      <= 1'b0;
            perdeuVida <= 1'b0;
        end else begin
            estado     <= estado_n;
            x_bola     <= x_n;
            y_bola     <= y_n;
            dir_x      <= dir_x_n;
            dir_y      <= dir_y_n;
            cnt        <= cnt_n;
            vidas      <= vidas_n;
            bateu      <= bateu_n;
            perdeuVida <= perdeu_n;
        end
    end

    always_comb begin
        estado_n = estado;
        x_n      = x_bola;
        y_n      = y_bola;
        dir_x_n  = dir_x;
        dir_y_n  = dir_y;
        vidas_n  = vidas;
        bateu_n  = 1'b0;
        perdeu_n = 1'b0;
        cnt_n    = pausa ? cnt : (tick ? '0 : cnt + CW'(1));

        case (estado)
            ESPERA: begin
                x_n = x_nave + X_OFS;
                y_n = y_nave - 10'(TAM_BOLA);
                if (lancar && !pausa) begin
                    estado_n = MOVENDO;
                    dir_x_n  = 1'b0;
                    dir_y_n  = 1'b1;
                    cnt_n    = '0;
                end
            end
            MOVENDO: begin
                if (tick) begin
                    // Axes are independent so a corner flips both directions at once.
                    if (!dir_x) begin
                        if (xb + T11 + P11 >= 11'd640) begin
                            x_n     = 10'(640 - TAM_BOLA);
                            dir_x_n = 1'b1;
                        end else begin
                            x_n = x_bola + 10'(PASSO);
                        end
                    end else if (xb <= P11) begin
                        x_n     = '0;
                        dir_x_n = 1'b0;
                    end else begin
                        x_n = x_bola - 10'(PASSO);
                    end

                    if (dir_y) begin
                        if (yb <= P11) begin
                            y_n     = '0;
                            dir_y_n = 1'b0;
                        end else begin
                            y_n = y_bola - 10'(PASSO);
                        end
                    end else if (hit) begin
                        y_n     = y_nave - 10'(TAM_BOLA);
                        dir_y_n = 1'b1;
                        bateu_n = 1'b1;
                    end else if (yb + T11 + P11 >= 11'd480) begin
                        estado_n = PERDEU;
                        perdeu_n = 1'b1;
                        if (vidas != 3'd0)
                            vidas_n = vidas - 3'd1;
                    end else begin
                        y_n = y_bola + 10'(PASSO);
                    end
                end
            end
            PERDEU:  estado_n = (vidas == 3'd0) ? FIM : ESPERA;
            FIM:     estado_n = FIM;
            default: estado_n = ESPERA;
        endcase
    end

endmodule

// File: tb/tb_bola.sv
// Bench for bola: tracking table, scripted wall/ceiling/hit/pause/miss sequences and
// a randomized run, all checked every cycle against a rule-level model of the game.
module tb_bola;

    localparam int TD = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset, reiniciarJogo, pausa, lancar;
    logic [9:0] x_nave, y_nave, x_bola, y_bola;
    logic       bateu, perdeuVida, fimDeJogo;
    logic [2:0] vidas;

    bola #(.TICK_DIV(TD)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .reiniciarJogo (reiniciarJogo),
        .pausa         (pausa),
        .lancar        (lancar),
        .x_nave        (x_nave),
        .y_nave        (y_nave),
        .x_bola        (x_bola),
        .y_bola        (y_bola),
        .bateu         (bateu),
        .perdeuVida    (perdeuVida),
        .vidas         (vidas),
        .fimDeJogo     (fimDeJogo)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [9:0] xn;
        logic [9:0] yn;
        logic [9:0] ex;
        logic [9:0] ey;
    } vec_t;
    vec_t tbl [6];
    int   wall_xs [8];

    // Game model: phase 0 riding paddle, 1 flying, 2 just lost, 3 game over.
    int m_ph, mx, my, mdx, mdy, mcnt, mvid;
    bit mbat, mper;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; mx = 338; my = 402; mdx = 0; mdy = 1; mcnt = 0; mvid = 3;
        mbat = 0; mper = 0;
    endtask

    task automatic model_clock();
        int  nx, ny, ndx, ndy, ncnt, nvid, nph, xn, yn;
        bit  tick;
        nx = mx; ny = my; ndx = mdx; ndy = mdy; nvid = mvid; nph = m_ph;
        xn = int'(x_nave); yn = int'(y_nave);
        tick = (mcnt == TD - 1) && !pausa;
        ncnt = pausa ? mcnt : (tick ? 0 : mcnt + 1);
        mbat = 0; mper = 0;
        if (m_ph == 0) begin
            nx = (xn + 45 / 2 - 8 / 2) % 1024;
            ny = (yn - 8 + 1024) % 1024;
            if (lancar && !pausa) begin
                nph = 1; ndx = 0; ndy = 1; ncnt = 0;
            end
        end else if (m_ph == 1 && tick) begin
            if (mdx == 0) begin
                if (mx + 10 >= 640) begin nx = 632; ndx = 1; end
                else nx = mx + 2;
            end else begin
                if (mx <= 2) begin nx = 0; ndx = 0; end
                else nx = mx - 2;
            end
            if (mdy == 1) begin
                if (my <= 2) begin ny = 0; ndy = 0; end
                else ny = my - 2;
            end else if (my + 8 <= yn && my + 10 >= yn && mx + 8 > xn && mx < xn + 45) begin
                ny = yn - 8; ndy = 1; mbat = 1;
            end else if (my + 10 >= 480) begin
                nph = 2; nvid = mvid - 1; mper = 1;
            end else begin
                ny = my + 2;
            end
        end else if (m_ph == 2) begin
            nph = (mvid == 0) ? 3 : 0;
        end
        mx = nx; my = ny; mdx = ndx; mdy = ndy; mcnt = ncnt; mvid = nvid; m_ph = nph;
    endtask

    task automatic step();
        model_clock();
        @(posedge CLOCK_50);
        #1;
        chk("x_bola", x_bola, mx);
        chk("y_bola", y_bola, my);
        chk("bateu", bateu, mbat);
        chk("perdeuVida", perdeuVida, mper);
        chk("vidas", vidas, mvid);
        chk("fimDeJogo", fimDeJogo, m_ph == 3);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_x"}, x_bola, 338);
        chk({nm, "_y"}, y_bola, 402);
        chk({nm, "_bateu"}, bateu, 0);
        chk({nm, "_perdeu"}, perdeuVida, 0);
        chk({nm, "_vidas"}, vidas, 3);
        chk({nm, "_fim"}, fimDeJogo, 0);
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge arrives.
    task automatic async_rst(input bit via_restart);
        #3;
        if (via_restart) reiniciarJogo = 1'b1;
        else reset = 1'b1;
        #1;
        model_reset();
        check_reset_vals(via_restart ? "restart" : "midreset");
        reiniciarJogo = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int g, sx, sy, rem;
        tbl[0] = '{10'd100,  10'd410, 10'd118,  10'd402};
        tbl[1] = '{10'd0,    10'd410, 10'd18,   10'd402};
        tbl[2] = '{10'd600,  10'd410, 10'd618,  10'd402};
        tbl[3] = '{10'd320,  10'd410, 10'd338,  10'd402};
        tbl[4] = '{10'd1000, 10'd8,   10'd1018, 10'd0};
        tbl[5] = '{10'd7,    10'd100, 10'd25,   10'd92};
        wall_xs = '{620, 622, 624, 626, 628, 630, 632, 630};

        reset = 1'b1; reiniciarJogo = 1'b0; pausa = 1'b0; lancar = 1'b0;
        x_nave = 10'd320; y_nave = 10'd410;
        model_reset();
        #2;
        check_reset_vals("reset");
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;

        // Paddle tracking table, one-cycle latency
        for (int i = 0; i < 6; i++) begin
            x_nave = tbl[i].xn;
            y_nave = tbl[i].yn;
            step();
            chk("trk_x", x_bola, tbl[i].ex);
            chk("trk_y", y_bola, tbl[i].ey);
            chk("trk_vidas", vidas, 3);
        end

        // Launch toward the right wall
        x_nave = 10'd600; y_nave = 10'd410;
        step();
        lancar = 1'b1;
        step();
        lancar = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat (TD) step();
            chk("wall_x", x_bola, wall_xs[k]);
            chk("wall_y", y_bola, 400 - 2 * k);
        end

        // Ceiling
        g = 0;
        while (!(m_ph == 1 && my == 2 && mdy == 1) && g < 2000) begin
            step();
            g++;
        end
        chk("ceil_reach", y_bola, 2);
        repeat (TD) step();
        chk("ceil_y0", y_bola, 0);
        repeat (TD) step();
        chk("ceil_y2", y_bola, 2);

        // Paddle follows the ball until it bounces off
        g = 0;
        while (!mbat && g < 4000) begin
            x_nave = (mx >= 10) ? 10'(mx - 10) : 10'd0;
            step();
            g++;
        end
        chk("hit_bateu", bateu, 1);
        chk("hit_y", y_bola, 402);
        step();
        chk("hit_pulse_end", bateu, 0);

        // Pause mid-flight from a random counter phase
        repeat ($urandom_range(0, 3)) step();
        sx = mx; sy = my; rem = TD - mcnt;
        pausa = 1'b1;
        repeat (100) begin
            lancar = 1'($urandom_range(0, 1));
            step();
        end
        lancar = 1'b0;
        chk("pause_x", x_bola, sx);
        chk("pause_y", y_bola, sy);
        pausa = 1'b0;
        repeat (rem - 1) step();
        chk("resume_hold", x_bola, sx);
        step();
        chk("resume_move", x_bola != 10'(sx), 1);

        // Three misses with the paddle kept away
        for (int life = 0; life < 3; life++) begin
            g = 0;
            while (!mper && g < 8000) begin
                pausa = ($urandom_range(0, 7) == 0);
                x_nave = (mx < 300) ? 10'd560 : 10'd0;
                step();
                g++;
            end
            pausa = 1'b0;
            chk("miss_pulse", perdeuVida, 1);
            chk("miss_bateu", bateu, 0);
            chk("miss_vidas", vidas, 2 - life);
            step();
            chk("miss_pulse_end", perdeuVida, 0);
            step();
            if (life < 2) begin
                chk("miss_back_to_wait", fimDeJogo, 0);
                lancar = 1'b1;
                step();
                lancar = 1'b0;
            end
        end
        chk("gameover_fim", fimDeJogo, 1);
        chk("gameover_vidas", vidas, 0);
        sx = mx; sy = my;
        lancar = 1'b1;
        repeat (20) step();
        lancar = 1'b0;
        chk("fim_hold", fimDeJogo, 1);
        chk("fim_frozen_x", x_bola, sx);
        chk("fim_frozen_y", y_bola, sy);

        async_rst(1'b1);

        // Randomized play
        repeat (3000) begin
            pausa  = ($urandom_range(0, 4) == 0);
            lancar = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) x_nave = 10'($urandom_range(0, 639));
            if ($urandom_range(0, 31) == 0) y_nave = 10'($urandom_range(300, 470));
            step();
        end

        // Reset in flight
        pausa = 1'b0; lancar = 1'b0;
        async_rst(1'b1);
        x_nave = 10'd200; y_nave = 10'd410;
        step();
        lancar = 1'b1;
        step();
        lancar = 1'b0;
        repeat (30) step();
        async_rst(1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bola.md
# bola

Ball engine for the paddle game: the consuming end of the paddle interface. Takes the paddle position and launch request, moves the ball on a fixed tick, and reflects it off the walls and the paddle. Reports paddle hits on `bateu` (closing the paddle's launch handshake), counts lives, and drives ball coordinates to the video renderer.

## Interface
Parameters:
- `TICK_DIV`, default 250000: clock cycles per movement step. 200 Hz at 50 MHz.
- `PASSO`, default 2: pixels moved per step on each axis.
- `LARG_NAVE`, default 45: paddle width in pixels.
- `TAM_BOLA`, default 8: ball side in pixels.
- `VIDAS_INICIAIS`, default 3: lives after reset.

Ports:
- `CLOCK_50` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `reiniciarJogo` in 1: ORed with `reset`. Same asynchronous effect.
- `pausa` in 1: 1 freezes all motion and the tick counter.
- `lancar` in 1: launch request, level-sampled.
- `x_nave` in 10: paddle left x.
- `y_nave` in 10: paddle top y.
- `x_bola` out 10: ball left x, registered.
- `y_bola` out 10: ball top y, registered.
- `bateu` out 1: one-cycle pulse on a paddle hit.
- `perdeuVida` out 1: one-cycle pulse on a missed ball.
- `vidas` out 3: remaining lives.
- `fimDeJogo` out 1: high while in FIM.

## Operation
- Screen is 640x480. Coordinates are unsigned 10-bit. All comparisons are done at 11 bits, so there is no wrap.
- States: ESPERA, MOVENDO, PERDEU, FIM. Direction registers: `dir_x` (0 = right), `dir_y` (1 = up).
- ESPERA: ball rides on the paddle.
  - Every cycle: `x_bola <= x_nave + LARG_NAVE/2 - TAM_BOLA/2`, `y_bola <= y_nave - TAM_BOLA`.
  - If `lancar=1` and `pausa=0`: go to MOVENDO, set `dir_x=0`, `dir_y=1`, clear the tick counter.
- MOVENDO: on each tick, both axes update independently in the same cycle, so a corner reflects both axes.
  - Right: if `x_bola+TAM_BOLA+PASSO >= 640`, then `x_bola=640-TAM_BOLA` and `dir_x=1`. Else `x_bola += PASSO`.
  - Left: if `x_bola <= PASSO`, then `x_bola=0` and `dir_x=0`. Else `x_bola -= PASSO`.
  - Up: if `y_bola <= PASSO`, then `y_bola=0` and `dir_y=0`. Else `y_bola -= PASSO`.
  - Down, paddle hit. All of these must hold:
    - `y_bola+TAM_BOLA <= y_nave`
    - `y_bola+TAM_BOLA+PASSO >= y_nave`
    - `x_bola+TAM_BOLA > x_nave`
    - `x_bola < x_nave+LARG_NAVE`
  - On a paddle hit: `y_bola=y_nave-TAM_BOLA`, `dir_y=1`, pulse `bateu`.
  - Down, otherwise: if `y_bola+TAM_BOLA+PASSO >= 480`, go to PERDEU, `vidas -= 1`, pulse `perdeuVida`. Else `y_bola += PASSO`.
  - The paddle test has priority over the floor test.
- PERDEU lasts one cycle. Next state is FIM if `vidas==0`, else ESPERA.
- FIM: ball frozen, `lancar` ignored. Only `reset` or `reiniciarJogo` leaves FIM.
- `vidas` never underflows. It only decrements on the MOVENDO→PERDEU transition, which cannot occur with `vidas==0`.

## Timing
- Reset values:
  - state ESPERA, `dir_x=0`, `dir_y=1`, tick counter 0.
  - `x_bola=338`, `y_bola=402` (the default paddle rest position 320/410).
  - `bateu=0`, `perdeuVida=0`, `vidas=VIDAS_INICIAIS`, `fimDeJogo=0`.
- Tick fires when the counter equals `TICK_DIV-1` and `pausa=0`. The counter then wraps to 0.
- While `pausa=1` the counter holds. In ESPERA the ball still tracks the paddle.
- Position update, `bateu` and `perdeuVida` all register on the tick cycle. They are visible the following cycle.
- `bateu` and `perdeuVida` are high for exactly one cycle, never both at once.
- ESPERA tracking has 1-cycle latency from `x_nave`/`y_nave`.
- First movement step comes `TICK_DIV` cycles after the launch cycle.
- A `reset`/`reiniciarJogo` assertion mid-flight returns all outputs to their reset values immediately. It is asynchronous.

## Test plan
All scenarios use `TICK_DIV=4`.
- **Paddle tracking:** after reset, drive `x_nave=100`, `y_nave=410` → one cycle later `x_bola=118`, `y_bola=402`, `vidas=3`, `bateu=0`.
- **Launch and right wall:** `x_nave=600`, pulse `lancar` → `x_bola` steps 620, 622, …, 630, 632, then 630 with `dir_x=1`. `y_bola` decrements by 2 per tick.
- **Ceiling:** ball moving up reaches `y_bola=2` → next step `y_bola=0`, `dir_y=0`. Following step `y_bola=2`.
- **Paddle hit:** ball descending at `y_bola=400`, `x_bola=110`, paddle at 100/410 → next step `y_bola=402`, `dir_y=1`, `bateu` high for exactly 1 cycle.
- **Miss and game over:** paddle at `x_nave=500`, ball descending at `x_bola=50`, `y_bola=470` → `perdeuVida` pulses, `vidas` 3→2, state back to ESPERA.
  - Repeat twice more → `vidas=0`, `fimDeJogo=1`, `lancar` ignored.
  - `reiniciarJogo` → `vidas=3`, `fimDeJogo=0`.
- **Pause:** `pausa=1` for 100 cycles mid-flight → `x_bola`, `y_bola` and directions unchanged. After release the first step occurs after the remaining tick count.
